// File: rtl/or_sched_pkg.sv
// Shared types, default parameters and the round-robin pick function
// for the OR-unit scheduler.
package or_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_WIDTH   = 8;
  localparam int DEF_CNT_W   = 16;
  localparam int MAX_REQ     = 8;

  // First valid requester strictly after 'last', wrapping modulo n.
  // Scanning from the farthest candidate down to the nearest lets the
  // nearest valid one overwrite the result. Returns 0 when none is valid.
  function automatic logic [2:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                         input logic [2:0]         last,
                                         input int                 n);
    logic [2:0] pick;
    logic [2:0] cand;
    int         idx;
    pick = '0;
    for (int k = MAX_REQ; k >= 1; k--) begin
      if (k <= n) begin
        idx  = (int'(last) + k) % n;
        cand = 3'(idx);
        if (valid[cand]) pick = cand;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/or_gate_8bit.sv
// One 8-bit slice of the shared bitwise-OR datapath.
module or_gate_8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] y
);

  assign y = a | b;

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant and grant index,
// searching upward from the requester after last_grant.
module rr_arbiter
  import or_sched_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  localparam int IDW    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDW-1:0]     last,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDW-1:0]     idx,
  output logic               any
);

  logic [MAX_REQ-1:0] valid_ext;
  logic [2:0]         last_ext;
  logic [2:0]         pick;

  // Widen inputs to the package function's fixed size and decode the pick.
  always_comb begin
    valid_ext                = '0;
    valid_ext[NUM_REQ-1:0]   = valid;
    last_ext                 = '0;
    last_ext[IDW-1:0]        = last;
    pick                     = rr_pick(valid_ext, last_ext, NUM_REQ);
    idx                      = pick[IDW-1:0];
    any                      = |valid;
    grant                    = '0;
    if (any) grant[idx]      = 1'b1;
  end

endmodule

// File: rtl/or_unit_scheduler.sv
// Time-shares one WIDTH-bit OR datapath between NUM_REQ requesters with
// round-robin arbitration and a single ID-tagged response channel.
module or_unit_scheduler
  import or_sched_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int WIDTH   = DEF_WIDTH,
  parameter int CNT_W   = DEF_CNT_W,
  localparam int IDW    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [WIDTH-1:0]         rsp_data,
  output logic [IDW-1:0]           rsp_id,
  output logic                     busy,
  output logic [CNT_W-1:0]         op_count
);

  state_t               state;
  logic [IDW-1:0]       last_grant;
  logic [IDW-1:0]       id_q;
  logic [WIDTH-1:0]     op_a;
  logic [WIDTH-1:0]     op_b;
  logic [WIDTH-1:0]     or_res;
  logic [NUM_REQ-1:0]   grant;
  logic [IDW-1:0]       gidx;
  logic                 any_req;
  logic                 accept;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .valid (req_valid),
    .last  (last_grant),
    .grant (grant),
    .idx   (gidx),
    .any   (any_req)
  );

  for (genvar s = 0; s < WIDTH / 8; s++) begin : g_slice
    or_gate_8bit u_or (
      .a (op_a[s*8 +: 8]),
      .b (op_b[s*8 +: 8]),
      .y (or_res[s*8 +: 8])
    );
  end

  // Grant is only offered while idle; held low while reset is asserted.
  assign accept    = (state == IDLE) && any_req && rst_n;
  assign req_ready = accept ? grant : '0;
  assign busy      = (state != IDLE);

  // Operand capture at the accept edge; these feed only the datapath.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_a <= req_a[gidx*WIDTH +: WIDTH];
      op_b <= req_b[gidx*WIDTH +: WIDTH];
      id_q <= gidx;
    end
  end

  // Control FSM with registered response, ID and completion counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= IDW'(NUM_REQ - 1);
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_id     <= '0;
      op_count   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            last_grant <= gidx;
            state      <= EXEC;
          end
        end
        EXEC: begin
          rsp_data  <= or_res;
          rsp_id    <= id_q;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            op_count  <= sat_inc(op_count);
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_or_unit_scheduler.sv
// Bench for or_unit_scheduler: directed scenarios plus randomized traffic
// checked against a transaction-level round-robin model.
module tb_or_unit_scheduler;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int CW = 2;
  localparam int CMAX = 3;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [W-1:0]   rsp_data;
  logic [1:0]     rsp_id;
  logic           busy;
  logic [CW-1:0]  op_count;

  int n_asserts = 0;
  int n_fail    = 0;
  int cyc       = 0;

  // Model state
  logic [7:0] a_m [N];
  logic [7:0] b_m [N];
  int         last_m;
  int         cnt_m;
  int         last_grant_cyc;

  or_unit_scheduler #(.NUM_REQ(N), .WIDTH(W), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .busy      (busy),
    .op_count  (op_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_model(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++) begin
      if (v[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic drive_ops();
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = a_m[i];
      req_b[i*W +: W] = b_m[i];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction starting in IDLE; leaves the model updated and the
  // un-granted requests still asserted on req_valid.
  task automatic do_txn(input logic [N-1:0] v, input int stall, input bit chk_gap);
    int         g;
    logic [7:0] d;
    g = rr_model(v, last_m);
    d = a_m[g] | b_m[g];
    drive_ops();
    req_valid = v;
    rsp_ready = 1'b0;
    #1;
    chk("grant_ready", req_ready, 32'(1 << g));
    chk("idle_busy", busy, 0);
    if (chk_gap) chk("accept_gap", cyc - last_grant_cyc, 3);
    last_grant_cyc = cyc;
    tick();
    req_valid = v & ~N'(1 << g);
    #1;
    chk("exec_ready", req_ready, 0);
    chk("exec_rsp_valid", rsp_valid, 0);
    chk("exec_busy", busy, 1);
    tick();
    chk("resp_valid", rsp_valid, 1);
    chk("resp_data", rsp_data, d);
    chk("resp_id", rsp_id, g);
    for (int s = 0; s < stall; s++) begin
      tick();
      chk("stall_valid", rsp_valid, 1);
      chk("stall_data", rsp_data, d);
      chk("stall_id", rsp_id, g);
      chk("stall_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    cnt_m  = cnt_m + 1;
    last_m = g;
    chk("done_valid", rsp_valid, 0);
    chk("done_busy", busy, 0);
    chk("op_count", op_count, (cnt_m > CMAX) ? CMAX : cnt_m);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    last_m    = N - 1;
    cnt_m     = 0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    logic [N-1:0] pend;
    logic [N-1:0] v;
    int           g;

    // Reset state, with requests present while reset is held
    for (int i = 0; i < N; i++) begin a_m[i] = '0; b_m[i] = '0; end
    drive_ops();
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    rsp_ready = 1'b0;
    #3;
    chk("rst_ready", req_ready, 0);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_data", rsp_data, 0);
    chk("rst_id", rsp_id, 0);
    chk("rst_busy", busy, 0);
    chk("rst_count", op_count, 0);
    do_reset();

    // Single request: 0x0F | 0xA0 from requester 0
    a_m[0] = 8'h0F; b_m[0] = 8'hA0;
    do_txn(4'b0001, 0, 1'b0);
    req_valid = '0;
    tick();

    // Round-robin fairness with all requesters continuously asserted
    for (int i = 0; i < N; i++) begin a_m[i] = 8'(i * 16 + 1); b_m[i] = 8'(8'h80 >> i); end
    do_reset();
    do_txn(4'b1111, 0, 1'b0);
    chk("rr_first", last_m, 0);
    for (int k = 1; k < 5; k++) begin
      do_txn(4'b1111, 0, 1'b1);
      chk("rr_order", last_m, k % N);
    end
    req_valid = '0;
    tick();

    // Backpressure, then wrap from last_grant=2 with only 0 and 1 requesting
    do_reset();
    a_m[2] = 8'h3C; b_m[2] = 8'h41;
    do_txn(4'b0100, 5, 1'b0);
    chk("bp_last", last_m, 2);
    do_txn(4'b0011, 0, 1'b0);
    chk("wrap_first", last_m, 0);
    do_txn(4'b0010, 0, 1'b1);
    chk("wrap_second", last_m, 1);
    req_valid = '0;
    tick();

    // Reset during EXEC discards the in-flight result
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    #1;
    chk("mid_busy_pre", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_valid", rsp_valid, 0);
    chk("mid_busy", busy, 0);
    chk("mid_count", op_count, 0);
    chk("mid_ready", req_ready, 0);
    tick();
    chk("mid_hold_valid", rsp_valid, 0);
    rst_n = 1'b1;
    last_m = N - 1;
    cnt_m  = 0;
    tick();
    do_txn(4'b1111, 0, 1'b0);
    chk("post_rst_prio", last_m, 0);
    req_valid = '0;
    tick();

    // Counter saturation
    do_reset();
    for (int k = 0; k < 5; k++) begin
      do_txn(4'b1000, 0, 1'b0);
      req_valid = '0;
    end
    tick();
    chk("sat_hold", op_count, CMAX);

    // Randomized traffic; waiting requesters keep valid and operands
    do_reset();
    pend = '0;
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i]) begin
          a_m[i] = 8'($urandom);
          b_m[i] = 8'($urandom);
        end
      end
      v = pend | 4'($urandom_range(1, 15));
      g = rr_model(v, last_m);
      do_txn(v, $urandom_range(0, 3), 1'b0);
      pend = v & ~N'(1 << g);
    end
    req_valid = '0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
